rtlola_event_scheduler: RTL and testbench
=========================================

Name: rtlola_event_scheduler

Overview:
Low-level controller for the RTLola monitor. It timestamps incoming input events and periodic deadlines, and buffers them in a small event queue. It then pops one event at a time and sequences the evaluation layers of the stream datapath, one layer per cycle. It sits between the monitor's top-level input ports and the per-layer output-stream evaluators, and it drives the llc_*/q_* debug signals.

Parameters:
DATA_W, 64, width of each input value (signed)
TAG_W, 64, width of timestamp tag (signed, counts clock cycles)
QDEPTH, 4, event queue depth; power of two, >=2
PERIOD_CYCLES, 1000, cycles between periodic deadlines
NUM_LAYERS, 3, number of evaluation layers sequenced per event

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-low reset
en  in  1  global enable; low freezes all state
input_0  in  DATA_W  value of input stream 0
new_input_0  in  1  input_0 carries a new event this cycle
input_1  in  DATA_W  value of input stream 1
new_input_1  in  1  input_1 carries a new event this cycle
ev_input_0  out  DATA_W  popped event value 0 (0 if not in mask)
ev_input_1  out  DATA_W  popped event value 1 (0 if not in mask)
ev_mask  out  2  popped event input-present mask, bit i = input_i
ev_periodic  out  1  popped event contains a periodic deadline
llc_tag  out  TAG_W  timestamp of popped event
layer_en  out  NUM_LAYERS  one-hot layer evaluation strobe
llc_to_pop  out  1  scheduler is popping the queue head this cycle
llc_is_valid_event  out  1  ev_*/llc_tag hold an event under evaluation
q_push_valid  out  1  an event was pushed at the previous edge
q_pop_valid  out  1  the pop this cycle is from a non-empty queue
q_overflow  out  1  sticky: an event was dropped because the queue was full

Behaviour:
- Reset (rst=0, async): all outputs 0, tag counter 0, period counter 0, queue empty, FSM IDLE, q_overflow cleared.
- en=0: no counter, queue or FSM change; outputs hold; new_input_* ignored (events lost, no overflow flag).
- Tag counter: +1 every en cycle; wraps modulo 2^TAG_W.
- Period counter: counts 0..PERIOD_CYCLES-1 and wraps. deadline=1 when the counter equals PERIOD_CYCLES-1 and en=1.
- Event capture: at an edge with en and (new_input_0 | new_input_1 | deadline), form one entry:
  - tag = current tag
  - value_i = input_i if new_input_i, else 0
  - mask = {new_input_1, new_input_0}
  - periodic = deadline
  - Simultaneous inputs and deadline merge into one entry.
- Push: accepted if count<QDEPTH, or if a pop occurs at the same edge. Otherwise drop the entry and set q_overflow. q_push_valid is a registered 1-cycle pulse after each accepted push.
- Pointers wrap modulo QDEPTH. count is exact under simultaneous push and pop.
- FSM (registered):
  - IDLE: if en and count>0, go to POP.
  - POP: one cycle; llc_to_pop=1, q_pop_valid=1. At the edge leaving POP, latch head into ev_*/llc_tag, decrement count, set llc_is_valid_event=1, go to EVAL with k=0.
  - EVAL: layer_en = 1<<k for one cycle; k increments each cycle. After k=NUM_LAYERS-1, go to IDLE.
  - llc_is_valid_event stays 1 through all EVAL cycles and drops to 0 on entering IDLE. ev_* hold until the next pop.
- Timing: a push at edge E0 gives POP in cycle E1–E2, layer_en bit0 after E2, last layer after E(1+NUM_LAYERS), IDLE after E(2+NUM_LAYERS).
- Throughput: one event per NUM_LAYERS+2 cycles.
- Queue empty: FSM never enters POP; q_pop_valid never 1 on empty.
- Reset mid-EVAL: event abandoned, layer_en immediately 0, queue contents discarded.

Test Plan:
1. Reset, en=1, no inputs, 1000 cycles -> a periodic entry is pushed at the tag=999 edge; ev_periodic=1, ev_mask=00, llc_tag=999; layer_en pulses 001, 010, 100 on consecutive cycles; repeats with tag=1999.
2. 1 cycle with new_input_0=1, input_0=5, new_input_1=1, input_1=7 at tag=10 -> q_push_valid pulse; llc_to_pop 1 cycle later; ev_input_0=5, ev_input_1=7, ev_mask=11, llc_tag=10; 3 layer strobes; then IDLE.
3. Input event coinciding with the deadline edge at tag 999, input_0=3 only -> single entry: mask=01, ev_periodic=1, ev_input_1=0, llc_tag=999.
4. new_input_0=1 for 8 consecutive cycles with values 1..8 -> queue fills; overflow sets exactly once the 5th-or-later entry finds the queue full with no pop; popped tags are strictly increasing; q_overflow stays 1.
5. Drop rst low while layer_en=010 -> all outputs 0 asynchronously; after release, empty queue, tag restarts at 0.
6. en=0 for 50 cycles mid-EVAL with inputs toggling -> layer_en and tag frozen, no push; resumes exactly where it stopped.

Source files
------------

// File: rtl/rtlola_event_scheduler.sv
// rtlola_event_scheduler
// Low-level controller for the RTLola monitor. Stamps input events and
// periodic deadlines with a cycle tag and queues them in a small FIFO. It then
// pops one event at a time and strobes the evaluation layers in order, one
// layer per cycle. When en is low, all state is frozen.
module rtlola_event_scheduler #(
    parameter int DATA_W        = 64,
    parameter int TAG_W         = 64,
    parameter int QDEPTH        = 4,
    parameter int PERIOD_CYCLES = 1000,
    parameter int NUM_LAYERS    = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [DATA_W-1:0]     input_0,
    input  logic                  new_input_0,
    input  logic [DATA_W-1:0]     input_1,
    input  logic                  new_input_1,
    output logic [DATA_W-1:0]     ev_input_0,
    output logic [DATA_W-1:0]     ev_input_1,
    output logic [1:0]            ev_mask,
    output logic                  ev_periodic,
    output logic [TAG_W-1:0]      llc_tag,
    output logic [NUM_LAYERS-1:0] layer_en,
    output logic                  llc_to_pop,
    output logic                  llc_is_valid_event,
    output logic                  q_push_valid,
    output logic                  q_pop_valid,
    output logic                  q_overflow
);

    localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CNT_W = $clog2(QDEPTH + 1);
    localparam int PER_W = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
    localparam int K_W   = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_POP  = 2'd1;
    localparam logic [1:0] ST_EVAL = 2'd2;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] v0;
        logic [DATA_W-1:0] v1;
        logic [1:0]        mask;
        logic              periodic;
    } entry_t;

    // Timebase
    logic [TAG_W-1:0] tag_cnt;
    logic [PER_W-1:0] period_cnt;
    logic             period_last;
    logic             deadline;

    // Queue
    entry_t           mem [QDEPTH];
    entry_t           new_entry;
    entry_t           head;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             capture;
    logic             pop_now;
    logic             push_ok;
    logic             not_full;

    // Sequencer
    logic [1:0]       state;
    logic [K_W-1:0]   layer_idx;
    logic             last_layer;

    assign period_last = (period_cnt == PER_W'(PERIOD_CYCLES - 1));
    assign deadline    = en && period_last;
    assign capture     = en && (new_input_0 || new_input_1 || deadline);
    assign pop_now     = en && (state == ST_POP);
    assign not_full    = (count < CNT_W'(QDEPTH));
    // A pop at the same edge frees the head slot, so a full queue can still
    // take the new entry.
    assign push_ok     = capture && (not_full || pop_now);
    assign head        = mem[rd_ptr];
    assign last_layer  = (layer_idx == K_W'(NUM_LAYERS - 1));

    // Tag counter and period counter advance on every enabled cycle.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_cnt    <= '0;
            period_cnt <= '0;
        end else if (en) begin
            tag_cnt    <= tag_cnt + TAG_W'(1);
            period_cnt <= period_last ? '0 : period_cnt + PER_W'(1);
        end
    end

    // Build the candidate queue entry from this cycle's inputs and deadline.
    // NOTE: every field gets a value on every path so no latch is inferred.
    always_comb begin
        new_entry.tag      = tag_cnt;
        new_entry.v0       = new_input_0 ? input_0 : '0;
        new_entry.v1       = new_input_1 ? input_1 : '0;
        new_entry.mask     = {new_input_1, new_input_0};
        new_entry.periodic = deadline;
    end

    // Queue storage: written at the tail on an accepted push.
    // NOTE: the storage array is not reset; pointers and count define which
    // slots are valid, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= new_entry;
        end
    end

    // Queue pointers, occupancy, push pulse and sticky overflow flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            q_push_valid <= 1'b0;
            q_overflow   <= 1'b0;
        end else if (en) begin
            q_push_valid <= push_ok;
            if (capture && !push_ok) begin
                q_overflow <= 1'b1;
            end
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_now) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop_now})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Sequencer: IDLE -> POP (one cycle) -> EVAL (one cycle per layer) -> IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            layer_idx <= '0;
        end else if (en) begin
            case (state)
                ST_IDLE: begin
                    if (count != '0) begin
                        state <= ST_POP;
                    end
                end
                ST_POP: begin
                    state     <= ST_EVAL;
                    layer_idx <= '0;
                end
                ST_EVAL: begin
                    if (last_layer) begin
                        state <= ST_IDLE;
                    end else begin
                        layer_idx <= layer_idx + K_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Event register: captures the queue head when leaving POP and holds it
    // until the next pop; the valid flag spans the EVAL cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ev_input_0         <= '0;
            ev_input_1         <= '0;
            ev_mask            <= '0;
            ev_periodic        <= 1'b0;
            llc_tag            <= '0;
            llc_is_valid_event <= 1'b0;
        end else if (pop_now) begin
            ev_input_0         <= head.v0;
            ev_input_1         <= head.v1;
            ev_mask            <= head.mask;
            ev_periodic        <= head.periodic;
            llc_tag            <= head.tag;
            llc_is_valid_event <= 1'b1;
        end else if (en && (state == ST_EVAL) && last_layer) begin
            llc_is_valid_event <= 1'b0;
        end
    end

    // Status strobes decoded from the registered sequencer state.
    always_comb begin
        llc_to_pop  = (state == ST_POP);
        q_pop_valid = (state == ST_POP) && (count != '0);
        layer_en    = '0;
        if (state == ST_EVAL) begin
            layer_en = NUM_LAYERS'(1) << layer_idx;
        end
    end

endmodule

// File: tb/tb_rtlola_event_scheduler.sv
// Self-checking bench for rtlola_event_scheduler: a table of directed vectors,
// hand-written multi-cycle corner cases, and randomized traffic compared each
// cycle against a queue-based reference model.
module tb_rtlola_event_scheduler;

    localparam int DATA_W        = 64;
    localparam int TAG_W         = 64;
    localparam int QDEPTH        = 4;
    localparam int PERIOD_CYCLES = 1000;
    localparam int NUM_LAYERS    = 3;

    logic                  clk;
    logic                  rst;
    logic                  en;
    logic [DATA_W-1:0]     input_0;
    logic                  new_input_0;
    logic [DATA_W-1:0]     input_1;
    logic                  new_input_1;
    logic [DATA_W-1:0]     ev_input_0;
    logic [DATA_W-1:0]     ev_input_1;
    logic [1:0]            ev_mask;
    logic                  ev_periodic;
    logic [TAG_W-1:0]      llc_tag;
    logic [NUM_LAYERS-1:0] layer_en;
    logic                  llc_to_pop;
    logic                  llc_is_valid_event;
    logic                  q_push_valid;
    logic                  q_pop_valid;
    logic                  q_overflow;

    rtlola_event_scheduler #(
        .DATA_W(DATA_W), .TAG_W(TAG_W), .QDEPTH(QDEPTH),
        .PERIOD_CYCLES(PERIOD_CYCLES), .NUM_LAYERS(NUM_LAYERS)
    ) dut (
        .clk(clk), .rst(rst), .en(en),
        .input_0(input_0), .new_input_0(new_input_0),
        .input_1(input_1), .new_input_1(new_input_1),
        .ev_input_0(ev_input_0), .ev_input_1(ev_input_1),
        .ev_mask(ev_mask), .ev_periodic(ev_periodic), .llc_tag(llc_tag),
        .layer_en(layer_en), .llc_to_pop(llc_to_pop),
        .llc_is_valid_event(llc_is_valid_event),
        .q_push_valid(q_push_valid), .q_pop_valid(q_pop_valid),
        .q_overflow(q_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: dut=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [63:0] tag;
        logic [63:0] v0;
        logic [63:0] v1;
        logic [1:0]  mask;
        logic        per;
    } ent_t;

    ent_t        mq[$];
    ent_t        m_ev;
    int          phase;      // 0 idle, 1 popping, 2.. evaluating layer phase-2
    logic        m_pv;
    logic        m_ovf;
    logic [63:0] m_tag;

    task automatic model_reset();
        mq.delete();
        m_ev  = '{64'd0, 64'd0, 64'd0, 2'b00, 1'b0};
        phase = 0;
        m_pv  = 1'b0;
        m_ovf = 1'b0;
        m_tag = 64'd0;
    endtask

    task automatic model_step();
        bit   popping, start, dl;
        ent_t e;
        if (!en) return;
        popping = (phase == 1);
        start   = (phase == 0) && (mq.size() > 0);
        dl      = ((m_tag % 64'(PERIOD_CYCLES)) == 64'(PERIOD_CYCLES - 1));
        if (popping) m_ev = mq.pop_front();
        m_pv = 1'b0;
        if (new_input_0 || new_input_1 || dl) begin
            e.tag  = m_tag;
            e.v0   = new_input_0 ? input_0 : 64'd0;
            e.v1   = new_input_1 ? input_1 : 64'd0;
            e.mask = {new_input_1, new_input_0};
            e.per  = dl;
            if (mq.size() < QDEPTH) begin
                mq.push_back(e);
                m_pv = 1'b1;
            end else begin
                m_ovf = 1'b1;
            end
        end
        if (start)                        phase = 1;
        else if (phase == NUM_LAYERS + 1) phase = 0;
        else if (phase != 0)              phase = phase + 1;
        m_tag = m_tag + 64'd1;
    endtask

    task automatic model_check();
        logic [63:0] xl;
        xl = (phase >= 2) ? (64'd1 << (phase - 2)) : 64'd0;
        check("m.layer_en",  64'(layer_en), xl);
        check("m.to_pop",    64'(llc_to_pop), 64'(phase == 1));
        check("m.pop_valid", 64'(q_pop_valid), 64'((phase == 1) && (mq.size() > 0)));
        check("m.valid",     64'(llc_is_valid_event), 64'(phase >= 2));
        check("m.push_valid", 64'(q_push_valid), 64'(m_pv));
        check("m.overflow",  64'(q_overflow), 64'(m_ovf));
        check("m.ev0",       ev_input_0, m_ev.v0);
        check("m.ev1",       ev_input_1, m_ev.v1);
        check("m.mask",      64'(ev_mask), 64'(m_ev.mask));
        check("m.periodic",  64'(ev_periodic), 64'(m_ev.per));
        check("m.tag",       llc_tag, m_ev.tag);
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic e, input logic n0, input logic [63:0] v0,
                         input logic n1, input logic [63:0] v1);
        en = e; new_input_0 = n0; input_0 = v0; new_input_1 = n1; input_1 = v1;
    endtask

    task automatic idle();
        drive(1'b1, 1'b0, 64'd0, 1'b0, 64'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        model_check();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        drive(1'b0, 1'b0, 64'd0, 1'b0, 64'd0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        model_check();
        rst = 1'b1;
        idle();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        en, n0;
        logic [63:0] i0;
        logic        n1;
        logic [63:0] i1;
        logic        x_pv, x_pop, x_popv;
        logic [2:0]  x_layer;
        logic        x_valid;
        logic [1:0]  x_mask;
        logic [63:0] x_ev0, x_ev1, x_tag;
        logic        x_per;
    } vec_t;

    vec_t tbl[6];
    logic [63:0] got_v[$];
    logic [63:0] got_t[$];
    logic [63:0] exp_v[6];
    logic [63:0] exp_t[6];
    int dens;

    initial begin
        // Two-input event at tag 10, then pop, three layer strobes, idle.
        tbl[0] = '{1, 1, 64'd5, 1, 64'd7,    1, 0, 0, 3'b000, 0, 2'b00, 64'd0, 64'd0, 64'd0,  0};
        tbl[1] = '{1, 0, 64'hdead, 0, 64'd0, 0, 1, 1, 3'b000, 0, 2'b00, 64'd0, 64'd0, 64'd0,  0};
        tbl[2] = '{1, 0, 64'd0, 0, 64'd0,    0, 0, 0, 3'b001, 1, 2'b11, 64'd5, 64'd7, 64'd10, 0};
        tbl[3] = '{1, 0, 64'd0, 0, 64'd0,    0, 0, 0, 3'b010, 1, 2'b11, 64'd5, 64'd7, 64'd10, 0};
        tbl[4] = '{1, 0, 64'd0, 0, 64'd0,    0, 0, 0, 3'b100, 1, 2'b11, 64'd5, 64'd7, 64'd10, 0};
        tbl[5] = '{1, 0, 64'd0, 0, 64'd0,    0, 0, 0, 3'b000, 0, 2'b11, 64'd5, 64'd7, 64'd10, 0};

        rst = 1'b0;
        drive(1'b0, 1'b0, 64'd0, 1'b0, 64'd0);

        // ---- deadline alone and deadline merged with an input ----
        do_reset();
        check("rst.layer_en", 64'(layer_en), 64'd0);
        check("rst.tag", llc_tag, 64'd0);
        repeat (999) tick();
        drive(1'b1, 1'b1, 64'd3, 1'b0, 64'd0);
        tick();
        check("dl.push_valid", 64'(q_push_valid), 64'd1);
        idle();
        tick();
        check("dl.to_pop", 64'(llc_to_pop), 64'd1);
        tick();
        check("dl.layer0", 64'(layer_en), 64'b001);
        check("dl.periodic", 64'(ev_periodic), 64'd1);
        check("dl.mask", 64'(ev_mask), 64'b01);
        check("dl.ev0", ev_input_0, 64'd3);
        check("dl.ev1", ev_input_1, 64'd0);
        check("dl.tag", llc_tag, 64'd999);
        tick();
        check("dl.layer1", 64'(layer_en), 64'b010);
        tick();
        check("dl.layer2", 64'(layer_en), 64'b100);
        tick();
        check("dl.idle_layer", 64'(layer_en), 64'd0);
        check("dl.idle_valid", 64'(llc_is_valid_event), 64'd0);
        repeat (995) tick();
        check("dl2.push_valid", 64'(q_push_valid), 64'd1);
        tick();
        check("dl2.to_pop", 64'(llc_to_pop), 64'd1);
        tick();
        check("dl2.layer0", 64'(layer_en), 64'b001);
        check("dl2.tag", llc_tag, 64'd1999);
        check("dl2.periodic", 64'(ev_periodic), 64'd1);
        check("dl2.mask", 64'(ev_mask), 64'b00);

        // ---- table-driven single event ----
        do_reset();
        repeat (10) tick();
        for (int i = 0; i < 6; i++) begin
            drive(tbl[i].en, tbl[i].n0, tbl[i].i0, tbl[i].n1, tbl[i].i1);
            tick();
            check($sformatf("tbl%0d.push_valid", i), 64'(q_push_valid), 64'(tbl[i].x_pv));
            check($sformatf("tbl%0d.to_pop", i), 64'(llc_to_pop), 64'(tbl[i].x_pop));
            check($sformatf("tbl%0d.pop_valid", i), 64'(q_pop_valid), 64'(tbl[i].x_popv));
            check($sformatf("tbl%0d.layer_en", i), 64'(layer_en), 64'(tbl[i].x_layer));
            check($sformatf("tbl%0d.valid", i), 64'(llc_is_valid_event), 64'(tbl[i].x_valid));
            check($sformatf("tbl%0d.mask", i), 64'(ev_mask), 64'(tbl[i].x_mask));
            check($sformatf("tbl%0d.ev0", i), ev_input_0, tbl[i].x_ev0);
            check($sformatf("tbl%0d.ev1", i), ev_input_1, tbl[i].x_ev1);
            check($sformatf("tbl%0d.tag", i), llc_tag, tbl[i].x_tag);
            check($sformatf("tbl%0d.periodic", i), 64'(ev_periodic), 64'(tbl[i].x_per));
        end

        // ---- burst of 8 events: fill, overflow, ordered drain ----
        do_reset();
        repeat (5) tick();
        got_v.delete();
        got_t.delete();
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 1'b1, 64'(i), 1'b0, 64'd0);
            tick();
            check($sformatf("burst%0d.overflow", i), 64'(q_overflow), 64'(i >= 6));
            if (layer_en == 3'b001) begin
                got_v.push_back(ev_input_0);
                got_t.push_back(llc_tag);
            end
        end
        idle();
        for (int c = 0; c < 60; c++) begin
            tick();
            if (layer_en == 3'b001) begin
                got_v.push_back(ev_input_0);
                got_t.push_back(llc_tag);
            end
        end
        exp_v = '{64'd1, 64'd2, 64'd3, 64'd4, 64'd5, 64'd8};
        exp_t = '{64'd5, 64'd6, 64'd7, 64'd8, 64'd9, 64'd12};
        check("burst.pop_count", 64'(got_v.size()), 64'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < got_v.size()) begin
                check($sformatf("burst.val%0d", i), got_v[i], exp_v[i]);
                check($sformatf("burst.tag%0d", i), got_t[i], exp_t[i]);
            end
        end
        check("burst.overflow_sticky", 64'(q_overflow), 64'd1);

        // ---- asynchronous reset in the middle of evaluation ----
        do_reset();
        drive(1'b1, 1'b1, 64'h55, 1'b0, 64'd0);
        tick();
        idle();
        tick();
        tick();
        tick();
        check("arst.pre_layer", 64'(layer_en), 64'b010);
        #2 rst = 1'b0;
        #1;
        check("arst.layer_en", 64'(layer_en), 64'd0);
        check("arst.valid", 64'(llc_is_valid_event), 64'd0);
        check("arst.ev0", ev_input_0, 64'd0);
        check("arst.mask", 64'(ev_mask), 64'd0);
        check("arst.to_pop", 64'(llc_to_pop), 64'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        drive(1'b1, 1'b1, 64'h66, 1'b0, 64'd0);
        tick();
        idle();
        tick();
        tick();
        check("arst.new_layer", 64'(layer_en), 64'b001);
        check("arst.new_tag", llc_tag, 64'd0);
        check("arst.new_ev0", ev_input_0, 64'h66);
        repeat (10) tick();

        // ---- enable low for 50 cycles mid-evaluation ----
        do_reset();
        repeat (20) tick();
        drive(1'b1, 1'b1, 64'd9, 1'b0, 64'd0);
        tick();
        idle();
        tick();
        tick();
        tick();
        check("frz.pre_layer", 64'(layer_en), 64'b010);
        for (int c = 0; c < 50; c++) begin
            drive(1'b0, c[0], 64'(c + 100), ~c[0], 64'(c + 200));
            tick();
        end
        check("frz.layer_held", 64'(layer_en), 64'b010);
        check("frz.no_push", 64'(q_push_valid), 64'd0);
        idle();
        tick();
        check("frz.resume_layer", 64'(layer_en), 64'b100);
        tick();
        check("frz.resume_idle", 64'(layer_en), 64'd0);
        drive(1'b1, 1'b1, 64'h77, 1'b0, 64'd0);
        tick();
        idle();
        tick();
        tick();
        check("frz.next_tag", llc_tag, 64'd26);
        check("frz.next_ev0", ev_input_0, 64'h77);

        // ---- randomized traffic against the model ----
        do_reset();
        for (int blk = 0; blk < 12; blk++) begin
            dens = int'($urandom_range(0, 5));
            for (int c = 0; c < 250; c++) begin
                drive($urandom_range(0, 9) != 0,
                      $urandom_range(0, 15) < dens, {$urandom, $urandom},
                      $urandom_range(0, 15) < dens, {$urandom, $urandom});
                tick();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
